// File: rtl/delay_arbiter.sv
// delay_arbiter: one tick-driven delay counter shared by NREQ requesters.
// A round-robin arbiter grants one requester, counts its requested number
// of tick strobes, then pulses that requester's done line for one cycle.
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   tick  - one-cycle enable strobe from the tick generator
//   req   - per-channel request level, held until done or abort
//   dly   - packed delays, channel i uses dly[CW*i +: CW]
//   gnt   - registered one-hot grant
//   done  - registered one-cycle completion pulse per channel
//   busy  - high whenever the arbiter is not idle
//   cnt   - ticks counted so far for the current grant (debug)
module delay_arbiter #(
  parameter int NREQ = 4,
  parameter int CW   = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] dly,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [CW-1:0]      cnt
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t          state, state_n;
  logic [IW-1:0]   ptr, ptr_n;
  logic [IW-1:0]   idx, idx_n;
  logic [CW-1:0]   tgt, tgt_n;
  logic [CW-1:0]   cnt_n;
  logic [NREQ-1:0] gnt_n, done_n;

  logic            found;
  logic [IW-1:0]   sel;
  logic [IW-1:0]   cand;

  // Round-robin pick: first asserted request scanning ptr, ptr+1, ...
  // The IW-bit addition wraps naturally because NREQ is a power of two.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = ptr + IW'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    idx_n   = idx;
    tgt_n   = tgt;
    cnt_n   = cnt;
    gnt_n   = gnt;
    done_n  = '0;
    case (state)
      IDLE: begin
        if (found) begin
          idx_n      = sel;
          tgt_n      = dly[sel*CW +: CW];
          cnt_n      = '0;
          gnt_n      = '0;
          gnt_n[sel] = 1'b1;
          state_n    = RUN;
        end
      end
      RUN: begin
        // Abort wins over a coincident final tick.
        if (!req[idx]) begin
          gnt_n   = '0;
          ptr_n   = idx + 1'b1;
          state_n = IDLE;
        end else if (tgt == '0) begin
          // Zero delay: the grant is shown for one cycle so done still
          // follows a visible gnt, and no tick is required.
          gnt_n       = '0;
          done_n[idx] = 1'b1;
          state_n     = FIN;
        end else if (tick) begin
          cnt_n = cnt + 1'b1;
          if (cnt == tgt - 1'b1) begin
            gnt_n       = '0;
            done_n[idx] = 1'b1;
            state_n     = FIN;
          end
        end
      end
      FIN: begin
        ptr_n   = idx + 1'b1;
        state_n = IDLE;
      end
      default: begin
        gnt_n   = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      idx   <= '0;
      tgt   <= '0;
      cnt   <= '0;
      gnt   <= '0;
      done  <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      idx   <= idx_n;
      tgt   <= tgt_n;
      cnt   <= cnt_n;
      gnt   <= gnt_n;
      done  <= done_n;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_delay_arbiter.sv
// tb_delay_arbiter: self-checking bench for delay_arbiter.
// Expected grants and done events are queued when requests are driven and
// consumed by a monitor when the DUT raises gnt or pulses done.
module tb_delay_arbiter;

  logic        clk;
  logic        rst;
  logic        tick;
  logic [3:0]  req;
  logic [55:0] dly;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        busy;
  logic [13:0] cnt;

  typedef struct {
    int ch;
    int cnt;
  } exp_t;

  exp_t done_q[$];
  int   gnt_q[$];

  int   n_checks = 0;
  int   n_errors = 0;
  int   tick_mode = 0;  // 0 off, 1 every 4th cycle, 2 held high
  int   tphase = 0;
  logic last_tick = 1'b0;
  logic [3:0] prev_gnt = '0;

  delay_arbiter #(.NREQ(4), .CW(14)) dut (
    .clk  (clk),
    .rst  (rst),
    .tick (tick),
    .req  (req),
    .dly  (dly),
    .gnt  (gnt),
    .done (done),
    .busy (busy),
    .cnt  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard consumer and invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_gnt = '0;
    end else begin
      check("gnt_onehot0", 32'($onehot0(gnt)), 1);
      check("done_onehot0", 32'($onehot0(done)), 1);
      if (done != '0) begin
        check("done_after_gnt", 32'(done & prev_gnt), 32'(done));
        if (done_q.size() == 0) begin
          check("done_unexpected", 32'(done), 0);
        end else begin
          exp_t e;
          e = done_q.pop_front();
          check("done_ch", 32'(done), 32'(1) << e.ch);
          check("done_cnt", 32'(cnt), e.cnt);
        end
      end
      if (gnt != '0 && prev_gnt == '0) begin
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", 32'(gnt), 0);
        end else begin
          int g;
          g = gnt_q.pop_front();
          check("gnt_order", 32'(gnt), 32'(1) << g);
        end
      end
      prev_gnt = gnt;
    end
  end

  task automatic step();
    tick = (tick_mode == 2) || (tick_mode == 1 && (tphase % 4) == 3);
    @(posedge clk);
    #1;
    last_tick = tick;
    tphase++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick = 1'b0;
    tick_mode = 0;
    step();
    step();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt", 32'(cnt), 0);
    rst = 1'b0;
    step();
  endtask

  task automatic request(input int ch, input int d, input bit expect_done);
    dly[ch*14 +: 14] = 14'(d);
    req[ch] = 1'b1;
    gnt_q.push_back(ch);
    if (expect_done) done_q.push_back('{ch: ch, cnt: d});
  endtask

  task automatic grant(input int ch);
    step();
    check("grant_gnt", 32'(gnt), 32'(1) << ch);
    check("grant_busy", 32'(busy), 1);
    check("grant_cnt", 32'(cnt), 0);
  endtask

  // Follows one grant from the grant edge to the IDLE cycle after FIN.
  task automatic run_grant(input int ch, input int tgt, input int budget, input bit drop);
    int n;
    bit fin;
    n = 0;
    fin = 1'b0;
    for (int c = 0; c < budget && !fin; c++) begin
      step();
      if (last_tick && tgt != 0) n++;
      if (n == tgt) begin
        fin = 1'b1;
        check("fin_done", 32'(done), 32'(1) << ch);
        check("fin_gnt", 32'(gnt), 0);
        check("fin_busy", 32'(busy), 1);
        check("fin_cnt", 32'(cnt), tgt);
        if (drop) req[ch] = 1'b0;
      end else begin
        check("run_cnt", 32'(cnt), n);
        check("run_gnt", 32'(gnt), 32'(1) << ch);
      end
    end
    if (!fin) check("done_timeout", 0, 1);
    step();
    check("post_busy", 32'(busy), 0);
    check("post_gnt", 32'(gnt), 0);
    check("post_done", 32'(done), 0);
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    dly = '0;
    tick = 1'b0;
    #3;
    check("async_rst_gnt", 32'(gnt), 0);
    check("async_rst_busy", 32'(busy), 0);
    do_reset();

    // Single request, tick every 4th cycle
    tick_mode = 1;
    tphase = 0;
    request(0, 3, 1);
    check("pre_grant_gnt", 32'(gnt), 0);
    grant(0);
    run_grant(0, 3, 40, 1);

    // ptr now 1: ch1 beats ch0 when both ask
    tick_mode = 0;
    request(1, 0, 1);
    request(0, 0, 1);
    grant(1);
    run_grant(1, 0, 4, 1);
    grant(0);
    run_grant(0, 0, 4, 1);

    // Zero delay
    request(2, 0, 1);
    grant(2);
    run_grant(2, 0, 4, 1);

    // Round robin with all requests held and tick held high
    do_reset();
    tick_mode = 2;
    for (int i = 0; i < 4; i++) request(i, 1, 1);
    gnt_q.push_back(0);
    done_q.push_back('{ch: 0, cnt: 1});
    for (int g = 0; g < 5; g++) begin
      grant(g % 4);
      run_grant(g % 4, 1, 8, g == 4);
    end
    req = '0;

    // Abort after two counted ticks, then ch0 is served before ch1
    request(1, 5, 0);
    grant(1);
    step();
    step();
    check("abort_cnt", 32'(cnt), 2);
    req[1] = 1'b0;
    step();
    check("abort_gnt", 32'(gnt), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    request(0, 1, 1);
    request(1, 1, 1);
    grant(0);
    run_grant(0, 1, 8, 1);
    grant(1);
    run_grant(1, 1, 8, 1);

    // Reset asserted between edges while running with cnt=4
    request(3, 10, 0);
    grant(3);
    for (int i = 0; i < 4; i++) step();
    check("midrun_cnt", 32'(cnt), 4);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_gnt", 32'(gnt), 0);
    check("midrst_done", 32'(done), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_cnt", 32'(cnt), 0);
    req = '0;
    step();
    rst = 1'b0;
    step();
    request(3, 2, 1);
    grant(3);
    run_grant(3, 2, 8, 1);

    // Tick on the grant edge is not counted (grant checks cnt=0 with tick high)
    request(0, 2, 1);
    grant(0);
    run_grant(0, 2, 8, 1);

    // dly change after grant is ignored
    request(1, 4, 1);
    grant(1);
    dly[14 +: 14] = 14'd1;
    run_grant(1, 4, 10, 1);

    // Maximum delay, no wrap
    request(2, 16383, 1);
    grant(2);
    run_grant(2, 16383, 17000, 1);

    step();
    step();
    check("gnt_q_empty", 32'(gnt_q.size()), 0);
    check("done_q_empty", 32'(done_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
